hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Backward-flowing companion to the pipelined controller. The controller pushes control forward D→E→M→W; this block returns stall, flush and forward-select signals to the earlier stages.
- Keeps its own shadow pipeline of register addresses and write/load/PC-write flags, so it needs only decode-stage inputs plus a few late-stage qualifiers.
- Adds a memory wait-state handshake with a timeout FSM.

Parameters:
- MAX_WAIT, 15: maximum consecutive MemReady-low cycles before MemTimeout is raised.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA1D  in  4  decode source register 1.
- RA2D  in  4  decode source register 2.
- WA3D  in  4  decode destination register.
- RegWriteD  in  1  decode instruction writes a register.
- MemtoRegD  in  1  decode instruction is a load.
- MemWriteD  in  1  decode instruction is a store.
- PCSrcD  in  1  decode instruction writes R15 (non-branch).
- CondExE  in  1  E-stage condition passed.
- BranchTakenE  in  1  E-stage branch taken (already qualified by CondExE).
- MemReady  in  1  data memory completes the M-stage access this cycle.
- ForwardAE  out  2  00 regfile, 10 ALUResultM, 01 ResultW.
- ForwardBE  out  2  same encoding, operand B.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- FlushD  out  1  bubble F/D register.
- FlushE  out  1  bubble D/E register.
- StallE  out  1  hold D/E and E/M registers (memory wait).
- FlushW  out  1  bubble M/W register (memory wait).
- MemTimeout  out  1  sticky error flag.

Behaviour:
- Shadow pipeline registers:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MemWriteE, PCSrcE.
  - M stage: WA3M, RegWriteM, MemReqM, PCSrcM.
  - W stage: WA3W, RegWriteW, PCSrcW.
- Reset (reset=0, async): all shadow flags 0, FSM=RUN, wait counter 0, MemTimeout 0. All outputs read 0 while reset is low.
- E→M transfer: RegWriteM ← RegWriteE&CondExE; PCSrcM ← PCSrcE&CondExE; MemReqM ← (MemtoRegE|MemWriteE)&CondExE.
- Forwarding (combinational from shadow state):
  - ForwardAE=10 if RegWriteM && WA3M==RA1E && RA1E!=15.
  - Else ForwardAE=01 if RegWriteW && WA3W==RA1E && RA1E!=15.
  - Else ForwardAE=00.
  - M has priority over W. ForwardBE is identical using RA2E.
- Hazard terms:
  - LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
  - PCWrPend = PCSrcD | PCSrcE | PCSrcM.
  - MemStall = (state==MEMWAIT or MemReqM) & !MemReady.
- Output equations:
  - StallF = LDRstall | PCWrPend | MemStall.
  - StallD = LDRstall | MemStall.
  - FlushD = !MemStall & (PCWrPend | PCSrcW | BranchTakenE).
  - FlushE = !MemStall & (LDRstall | BranchTakenE).
  - StallE = MemStall.
  - FlushW = MemStall.
- MemStall overrides all flushes: nothing advances, so nothing is squashed.
- Shadow update rules:
  - MemStall: E and M shadows hold; W shadow flags clear.
  - Otherwise: FlushE clears E flags (addresses don't-care); StallD holds nothing in the shadow, because the D inputs are held by the datapath.
- FSM:
  - RUN→MEMWAIT when MemReqM & !MemReady; counter=1.
  - MEMWAIT: counter increments each cycle MemReady=0; →RUN on MemReady=1, counter cleared.
  - When counter reaches MAX_WAIT, MemTimeout sets (sticky until reset) and FSM forces →RUN; MemStall drops and the pipeline continues with undefined load data.
- Simultaneous LDRstall and BranchTakenE: FlushE=1 and StallD=1. The branch redirect wins on the next fetch; FlushD also asserts.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs StallCount (32) and FlushCount (32).
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle FlushE=1.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - PC register index 4'd15;
  - FSM state typedef {RUN, MEMWAIT}.
- One sub-module is natural: mem_wait_fsm (state, counter, MemTimeout, MemStall).

Test Plan:
- ADD R1 at E→M, then SUB using R1 as RA1E, RegWriteM=1, WA3M=1 → ForwardAE=10, ForwardBE=00.
- WA3M=2 and WA3W=2 both writing, RA2E=2 → ForwardBE=10 (M priority); RegWriteM=0 → 01.
- LDR R3 in E (MemtoRegE=1), RA1D=3 → StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle ForwardAE=01.
- BranchTakenE=1 with CondExE=1 → FlushD=FlushE=1 same cycle, StallF=0. With CondExE=0 on a PCSrc instruction → no PCSrcM propagation.
- Load in M, MemReady low 3 cycles:
  - StallF/StallD/StallE/FlushW high 3 cycles, FlushE=0;
  - release on cycle 4; MemTimeout stays 0.
- MemReady held low, MAX_WAIT=15 → MemTimeout rises after 15 stall cycles, stays 1; async reset low mid-wait clears everything immediately.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forward selects, PC index,
// wait-FSM state and the shadow-pipeline stage records.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [3:0] PC_IDX = 4'd15;

  typedef enum logic {RUN, MEMWAIT} wait_state_e;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       pc_src;
  } e_shadow_t;

  typedef struct packed {
    logic [3:0] wa3;
    logic       reg_write;
    logic       mem_req;
    logic       pc_src;
  } m_shadow_t;

  typedef struct packed {
    logic [3:0] wa3;
    logic       reg_write;
    logic       pc_src;
  } w_shadow_t;

  // R15 is never forwarded: its E-stage value comes from the PC path.
  function automatic logic [1:0] fwd_sel(input logic wr_m, input logic [3:0] wa_m,
                                         input logic wr_w, input logic [3:0] wa_w,
                                         input logic [3:0] ra);
    if (ra == PC_IDX)          return FWD_RF;
    if (wr_m && (wa_m == ra))  return FWD_M;
    if (wr_w && (wa_w == ra))  return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_mem_wait_fsm.sv
// Memory wait-state tracker: stalls while the M-stage access is pending and
// abandons it after MAX_WAIT stalled cycles, raising a sticky timeout.
module mem_wait_fsm
  import hazard_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  wait_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             expired;

  // The expiry cycle itself releases the pipeline so the stalled access can leave M.
  assign expired   = (state == MEMWAIT) && (cnt == CNT_MAX);
  assign mem_stall = ((state == MEMWAIT) || mem_req) && !mem_ready && !expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state <= MEMWAIT;
            cnt   <= CNT_W'(1);
          end
        end
        MEMWAIT: begin
          if (mem_ready) begin
            state <= RUN;
            cnt   <= '0;
          end else if (expired) begin
            state       <= RUN;
            cnt         <= '0;
            mem_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: shadow E/M/W pipeline, forwarding, stall/flush generation and
// memory wait handling. HAZARD_PERF_CNT_EN adds StallCount/FlushCount.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       PCSrcD,
  input  logic       CondExE,
  input  logic       BranchTakenE,
  input  logic       MemReady,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       StallE,
  output logic       FlushW,
  output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  e_shadow_t e_q, e_next;
  m_shadow_t m_q;
  w_shadow_t w_q;
  logic      mem_stall, ldr_stall, pc_wr_pend;
  logic      stall_f, stall_d, flush_d, flush_e;

  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_wait (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (m_q.mem_req),
    .mem_ready   (MemReady),
    .mem_stall   (mem_stall),
    .mem_timeout (MemTimeout)
  );

  assign ForwardAE = fwd_sel(m_q.reg_write, m_q.wa3, w_q.reg_write, w_q.wa3, e_q.ra1);
  assign ForwardBE = fwd_sel(m_q.reg_write, m_q.wa3, w_q.reg_write, w_q.wa3, e_q.ra2);

  assign ldr_stall  = e_q.mem_to_reg & e_q.reg_write & ((RA1D == e_q.wa3) | (RA2D == e_q.wa3));
  assign pc_wr_pend = PCSrcD | e_q.pc_src | m_q.pc_src;

  // A memory stall freezes everything, so no flush may squash held stages.
  assign stall_f = ldr_stall | pc_wr_pend | mem_stall;
  assign stall_d = ldr_stall | mem_stall;
  assign flush_d = !mem_stall & (pc_wr_pend | w_q.pc_src | BranchTakenE);
  assign flush_e = !mem_stall & (ldr_stall | BranchTakenE);

  // Decode-side inputs are live during reset; keep every output quiet then.
  assign StallF = reset & stall_f;
  assign StallD = reset & stall_d;
  assign FlushD = reset & flush_d;
  assign FlushE = reset & flush_e;
  assign StallE = reset & mem_stall;
  assign FlushW = reset & mem_stall;

  always_comb begin
    e_next = '{ra1: RA1D, ra2: RA2D, wa3: WA3D, reg_write: RegWriteD,
               mem_to_reg: MemtoRegD, mem_write: MemWriteD, pc_src: PCSrcD};
    if (flush_e) begin
      e_next.reg_write  = 1'b0;
      e_next.mem_to_reg = 1'b0;
      e_next.mem_write  = 1'b0;
      e_next.pc_src     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (mem_stall) begin
      w_q.reg_write <= 1'b0;
      w_q.pc_src    <= 1'b0;
    end else begin
      e_q <= e_next;
      m_q <= '{wa3: e_q.wa3,
               reg_write: e_q.reg_write & CondExE,
               mem_req: (e_q.mem_to_reg | e_q.mem_write) & CondExE,
               pc_src: e_q.pc_src & CondExE};
      w_q <= '{wa3: m_q.wa3, reg_write: m_q.reg_write, pc_src: m_q.pc_src};
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + 1'b1;
      if (FlushE && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a stage-record model checked every cycle,
// plus hand-computed literal expectations along each scenario.
module tb_hazard_unit;

  localparam int MAX_WAIT = 15;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       ld;
    logic       st;
    logic       pc;
  } ins_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf, sd, fd, fe, se, fw;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  ins_t       d_cur = '0;
  logic       CondExE = 1'b1, BranchTakenE = 1'b0, MemReady = 1'b1;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, StallE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
  int unsigned scnt = 0, fcnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (d_cur.ra1),
    .RA2D         (d_cur.ra2),
    .WA3D         (d_cur.wa3),
    .RegWriteD    (d_cur.rw),
    .MemtoRegD    (d_cur.ld),
    .MemWriteD    (d_cur.st),
    .PCSrcD       (d_cur.pc),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .MemReady     (MemReady),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .StallE       (StallE),
    .FlushW       (FlushW),
    .MemTimeout   (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
`endif
  );

  always #5 clk = ~clk;

  // Model: one instruction record per stage, with the condition outcome kept alongside.
  ins_t me, mm, ww;
  bit   me_bub, mm_ok, ww_ok, mto;
  int   mwait;

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (mm_ok && mm.rw && mm.wa3 == ra) return 2'b10;
    if (ww_ok && ww.rw && ww.wa3 == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t calc();
    exp_t x;
    bit   ms, ldr, pcp;
    x   = '0;
    ms  = mm_ok && (mm.ld || mm.st) && !MemReady && (mwait < MAX_WAIT);
    ldr = me.ld && me.rw && (d_cur.ra1 == me.wa3 || d_cur.ra2 == me.wa3);
    pcp = d_cur.pc || me.pc || (mm.pc && mm_ok);
    x.fa = fwd(me.ra1);
    x.fb = fwd(me.ra2);
    x.sf = ldr || pcp || ms;
    x.sd = ldr || ms;
    x.fd = !ms && (pcp || (ww.pc && ww_ok) || BranchTakenE);
    x.fe = !ms && (ldr || BranchTakenE);
    x.se = ms;
    x.fw = ms;
    return x;
  endfunction

  always @(posedge clk or negedge reset) begin : mdl
    exp_t x;
    bit   req;
    if (!reset) begin
      me = '0; mm = '0; ww = '0;
      me_bub = 0; mm_ok = 0; ww_ok = 0; mto = 0; mwait = 0;
    end else begin
      x   = calc();
      req = mm_ok && (mm.ld || mm.st) && !MemReady;
`ifdef HAZARD_PERF_CNT_EN
      if (x.sf && scnt != 32'hFFFF_FFFF) scnt++;
      if (x.fe && fcnt != 32'hFFFF_FFFF) fcnt++;
`endif
      if (x.se) begin
        ww_ok = 0;
        mwait++;
      end else begin
        if (req) mto = 1;
        mwait = 0;
        ww = mm; ww_ok = mm_ok;
        mm = me; mm_ok = CondExE;
        me = d_cur; me_bub = x.fe;
        if (x.fe) begin
          me.rw = 0; me.ld = 0; me.st = 0; me.pc = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t x;
    x = reset ? calc() : '0;
    if (!reset || !me_bub) begin
      chk("ForwardAE", 32'(ForwardAE), 32'(x.fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(x.fb));
    end
    chk("StallF", 32'(StallF), 32'(x.sf));
    chk("StallD", 32'(StallD), 32'(x.sd));
    chk("FlushD", 32'(FlushD), 32'(x.fd));
    chk("FlushE", 32'(FlushE), 32'(x.fe));
    chk("StallE", 32'(StallE), 32'(x.se));
    chk("FlushW", 32'(FlushW), 32'(x.fw));
    chk("MemTimeout", 32'(MemTimeout), 32'(reset ? mto : 1'b0));
  end

  function automatic ins_t mk(input int ra1, input int ra2, input int wa3,
                              input bit rw, input bit ld, input bit st, input bit pc);
    ins_t i;
    i.ra1 = 4'(ra1); i.ra2 = 4'(ra2); i.wa3 = 4'(wa3);
    i.rw = rw; i.ld = ld; i.st = st; i.pc = pc;
    return i;
  endfunction

  // Present one cycle of inputs just after the edge; returns at the following negedge.
  task automatic cyc(input ins_t d, input bit cond = 1'b1, input bit bt = 1'b0, input bit rdy = 1'b1);
    @(posedge clk); #1;
    d_cur = d; CondExE = cond; BranchTakenE = bt; MemReady = rdy;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) cyc('0);
  endtask

  localparam ins_t NOP = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hazard-looking inputs: outputs must stay low.
    d_cur = mk(0, 0, 15, 1, 0, 0, 1); BranchTakenE = 1'b1;
    #7;
    chk("rst_StallF", 32'(StallF), 0);
    chk("rst_FlushD", 32'(FlushD), 0);
    chk("rst_FlushE", 32'(FlushE), 0);
    chk("rst_Timeout", 32'(MemTimeout), 0);
    #5 reset = 1'b1;
    drain();

    // ADD R1 then SUB R1: forward from M.
    cyc(mk(2, 3, 1, 1, 0, 0, 0));
    cyc(mk(1, 4, 5, 1, 0, 0, 0));
    cyc(NOP);
    chk("fwdM_A", 32'(ForwardAE), 32'h2);
    chk("fwdM_B", 32'(ForwardBE), 32'h0);
    drain();

    // R2 written in both M and W: M wins; then M write cancelled by CondExE=0.
    cyc(mk(0, 0, 2, 1, 0, 0, 0));
    cyc(mk(0, 0, 2, 1, 0, 0, 0));
    cyc(mk(0, 2, 9, 1, 0, 0, 0));
    cyc(NOP);
    chk("fwd_prio_B", 32'(ForwardBE), 32'h2);
    chk("fwd_prio_A", 32'(ForwardAE), 32'h0);
    drain();
    cyc(mk(0, 0, 2, 1, 0, 0, 0));
    cyc(mk(0, 0, 2, 1, 0, 0, 0));
    cyc(mk(0, 2, 9, 1, 0, 0, 0), 1'b0);
    cyc(NOP);
    chk("fwd_W_B", 32'(ForwardBE), 32'h1);
    drain();

    // Load-use: one-cycle stall, then forward from W.
    cyc(mk(4, 0, 3, 1, 1, 0, 0));
    cyc(mk(3, 6, 7, 1, 0, 0, 0));
    chk("ldr_StallF", 32'(StallF), 1);
    chk("ldr_StallD", 32'(StallD), 1);
    chk("ldr_FlushE", 32'(FlushE), 1);
    cyc(mk(3, 6, 7, 1, 0, 0, 0));
    chk("ldr_rel_StallD", 32'(StallD), 0);
    chk("ldr_rel_FlushE", 32'(FlushE), 0);
    cyc(NOP);
    chk("ldr_fwdW_A", 32'(ForwardAE), 32'h1);
    drain();

    // Taken branch.
    cyc(mk(5, 5, 6, 1, 0, 0, 0), 1'b1, 1'b1);
    chk("br_FlushD", 32'(FlushD), 1);
    chk("br_FlushE", 32'(FlushE), 1);
    chk("br_StallF", 32'(StallF), 0);
    drain();

    // PC write squashed by CondExE=0: nothing reaches M or W.
    cyc(mk(0, 0, 15, 1, 0, 0, 1));
    chk("pc_D_StallF", 32'(StallF), 1);
    cyc(NOP, 1'b0);
    chk("pc_E_StallF", 32'(StallF), 1);
    cyc(NOP);
    chk("pc_nc_M_StallF", 32'(StallF), 0);
    cyc(NOP);
    chk("pc_nc_W_FlushD", 32'(FlushD), 0);
    drain();

    // PC write with condition passed: pending through M, flush at W.
    cyc(mk(0, 0, 15, 1, 0, 0, 1));
    cyc(NOP);
    cyc(NOP);
    chk("pc_M_StallF", 32'(StallF), 1);
    cyc(NOP);
    chk("pc_W_StallF", 32'(StallF), 0);
    chk("pc_W_FlushD", 32'(FlushD), 1);
    drain();

    // Load in M with three not-ready cycles.
    cyc(mk(0, 0, 8, 1, 1, 0, 0));
    cyc(NOP);
    cyc(NOP, 1'b1, 1'b0, 1'b0);
    chk("mw1_StallF", 32'(StallF), 1);
    chk("mw1_StallE", 32'(StallE), 1);
    chk("mw1_FlushW", 32'(FlushW), 1);
    chk("mw1_FlushE", 32'(FlushE), 0);
    cyc(NOP, 1'b1, 1'b1, 1'b0);
    chk("mw2_StallD", 32'(StallD), 1);
    chk("mw2_FlushE", 32'(FlushE), 0);
    chk("mw2_FlushD", 32'(FlushD), 0);
    cyc(NOP, 1'b1, 1'b0, 1'b0);
    chk("mw3_StallE", 32'(StallE), 1);
    cyc(NOP);
    chk("mw4_StallE", 32'(StallE), 0);
    chk("mw4_StallF", 32'(StallF), 0);
    cyc(NOP);
    chk("mw_Timeout", 32'(MemTimeout), 0);
    drain();

    // Memory never ready: 15 stall cycles, forced release, sticky timeout.
    cyc(mk(0, 0, 9, 1, 1, 0, 0));
    cyc(NOP);
    for (int i = 1; i <= MAX_WAIT; i++) begin
      cyc(NOP, 1'b1, 1'b0, 1'b0);
      chk($sformatf("to_stall%0d", i), 32'(StallE), 1);
      chk($sformatf("to_flag%0d", i), 32'(MemTimeout), 0);
    end
    cyc(NOP, 1'b1, 1'b0, 1'b0);
    chk("to_release", 32'(StallE), 0);
    chk("to_flag_rel", 32'(MemTimeout), 0);
    cyc(NOP, 1'b1, 1'b0, 1'b0);
    chk("to_set", 32'(MemTimeout), 1);
    repeat (3) cyc(NOP);
    chk("to_sticky", 32'(MemTimeout), 1);

    // Async reset in the middle of another wait.
    cyc(mk(0, 0, 10, 1, 1, 0, 0));
    cyc(NOP);
    repeat (3) cyc(NOP, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_StallE", 32'(StallE), 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_StallE", 32'(StallE), 0);
    chk("arst_StallF", 32'(StallF), 0);
    chk("arst_Timeout", 32'(MemTimeout), 0);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (3) cyc(NOP);
    chk("post_rst_Timeout", 32'(MemTimeout), 0);
    chk("post_rst_StallE", 32'(StallE), 0);

`ifdef HAZARD_PERF_CNT_EN
    chk("StallCount", StallCount, scnt);
    chk("FlushCount", FlushCount, fcnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
